// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs. auxiliary multi-cycle requester.
// Latency: a grant in cycle N drives rf_we/rf_wr/rf_wd in cycle N+1. aux_ready is combinational.
// Backpressure: aux waits behind writeback. After STARVE_LIMIT blocked cycles, writeback is stalled for one cycle.
module regfile_wr_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_we,
  input  logic [2:0]  wb_wr,
  input  logic [15:0] wb_wd,
  input  logic        aux_valid,
  input  logic [2:0]  aux_wr,
  input  logic [15:0] aux_wd,
  output logic        aux_ready,
  output logic        stall_wb,
  output logic        rf_we,
  output logic [2:0]  rf_wr,
  output logic [15:0] rf_wd,
  output logic        err
);

  typedef enum logic {NORMAL, FORCE} state_t;

  localparam logic [3:0] LIMIT_M1 = 4'(STARVE_LIMIT - 1);

  state_t      state;
  logic [3:0]  wait_cnt;
  logic        pending;
  logic [2:0]  aux_wr_q;
  logic [15:0] aux_wd_q;

  logic aux_grant;
  logic blocked;
  logic violation;

  // Grant decode. Writeback owns the port in NORMAL; FORCE hands the slot to aux.
  always_comb begin
    aux_grant = 1'b0;
    blocked   = 1'b0;
    violation = 1'b0;
    if (rst_n) begin
      aux_grant = aux_valid && ((state == FORCE) || !wb_we);
    end
    blocked   = (state == NORMAL) && wb_we && aux_valid;
    violation = pending &&
                (!aux_valid || (aux_wr != aux_wr_q) || (aux_wd != aux_wd_q));
  end

  assign aux_ready = aux_grant;

  // Arbitration state, starvation counter and the one-cycle writeback stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= NORMAL;
      wait_cnt <= 4'd0;
      stall_wb <= 1'b0;
    end else begin
      case (state)
        NORMAL: begin
          if (blocked) begin
            if (wait_cnt == LIMIT_M1) begin
              state    <= FORCE;
              stall_wb <= 1'b1;
              wait_cnt <= 4'd0;
            end else if (wait_cnt != 4'd15) begin
              wait_cnt <= wait_cnt + 4'd1;
            end
          end else begin
            wait_cnt <= 4'd0;
          end
        end
        FORCE: begin
          state    <= NORMAL;
          stall_wb <= 1'b0;
          wait_cnt <= 4'd0;
        end
        default: begin
          state    <= NORMAL;
          stall_wb <= 1'b0;
          wait_cnt <= 4'd0;
        end
      endcase
    end
  end

  // Registered write port. Address and data hold when nobody is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we <= 1'b0;
      rf_wr <= 3'd0;
      rf_wd <= 16'd0;
    end else if (state == NORMAL && wb_we) begin
      rf_we <= 1'b1;
      rf_wr <= wb_wr;
      rf_wd <= wb_wd;
    end else if (aux_grant) begin
      rf_we <= 1'b1;
      rf_wr <= aux_wr;
      rf_wd <= aux_wd;
    end else begin
      rf_we <= 1'b0;
    end
  end

  // Aux stability tracking: snapshot the request on each blocked cycle, flag any change before grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending  <= 1'b0;
      aux_wr_q <= 3'd0;
      aux_wd_q <= 16'd0;
      err      <= 1'b0;
    end else begin
      if (blocked) begin
        pending  <= 1'b1;
        aux_wr_q <= aux_wr;
        aux_wd_q <= aux_wd;
      end else begin
        pending  <= 1'b0;
      end
      if (violation || (state == FORCE && !aux_valid)) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: vector table plus multi-cycle sequences.
// Two instances share the inputs: STARVE_LIMIT=4 (main) and STARVE_LIMIT=1.
// Outputs are sampled 1-2 time units after the rising edge.
module tb_regfile_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_we;
  logic [2:0]  wb_wr;
  logic [15:0] wb_wd;
  logic        aux_valid;
  logic [2:0]  aux_wr;
  logic [15:0] aux_wd;

  logic        aux_ready,  stall_wb,  rf_we,  err;
  logic [2:0]  rf_wr;
  logic [15:0] rf_wd;
  logic        aux_ready1, stall_wb1, rf_we1, err1;
  logic [2:0]  rf_wr1;
  logic [15:0] rf_wd1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  regfile_wr_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_we(wb_we), .wb_wr(wb_wr), .wb_wd(wb_wd),
    .aux_valid(aux_valid), .aux_wr(aux_wr), .aux_wd(aux_wd),
    .aux_ready(aux_ready), .stall_wb(stall_wb),
    .rf_we(rf_we), .rf_wr(rf_wr), .rf_wd(rf_wd), .err(err)
  );

  regfile_wr_arbiter #(.STARVE_LIMIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .wb_we(wb_we), .wb_wr(wb_wr), .wb_wd(wb_wd),
    .aux_valid(aux_valid), .aux_wr(aux_wr), .aux_wd(aux_wd),
    .aux_ready(aux_ready1), .stall_wb(stall_wb1),
    .rf_we(rf_we1), .rf_wr(rf_wr1), .rf_wd(rf_wd1), .err(err1)
  );

  typedef struct {
    logic        wb_we;
    logic [2:0]  wb_wr;
    logic [15:0] wb_wd;
    logic        aux_valid;
    logic [2:0]  aux_wr;
    logic [15:0] aux_wd;
    logic        exp_ready;
    logic        exp_we;
    logic [2:0]  exp_wr;
    logic [15:0] exp_wd;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [2:0] wr, input logic [15:0] wd,
                       input logic av, input logic [2:0] ar, input logic [15:0] ad);
    wb_we = we; wb_wr = wr; wb_wd = wd;
    aux_valid = av; aux_wr = ar; aux_wd = ad;
  endtask

  task automatic do_reset();
    drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    vecs[0] = '{1'b1, 3'd3, 16'hBEEF, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 3'd3, 16'hBEEF};
    vecs[1] = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 3'd3, 16'hBEEF};
    vecs[2] = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd5, 16'h1234, 1'b1, 1'b1, 3'd5, 16'h1234};
    vecs[3] = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 3'd5, 16'h1234};
    vecs[4] = '{1'b1, 3'd7, 16'hA5A5, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 3'd7, 16'hA5A5};
    vecs[5] = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd1, 16'h0F0F, 1'b1, 1'b1, 3'd1, 16'h0F0F};
    vecs[6] = '{1'b1, 3'd0, 16'hFFFF, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 3'd0, 16'hFFFF};
    vecs[7] = '{1'b0, 3'd6, 16'h1111, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 3'd0, 16'hFFFF};

    // Reset state, with an aux request presented during reset.
    rst_n = 1'b0;
    drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd2, 16'h5555);
    #2;
    chk("rst_aux_ready", aux_ready, 1'b0);
    chk("rst_stall_wb", stall_wb, 1'b0);
    chk("rst_rf_we", rf_we, 1'b0);
    chk("rst_rf_wr", rf_wr, 3'd0);
    chk("rst_rf_wd", rf_wd, 16'h0);
    chk("rst_err", err, 1'b0);
    do_reset();

    // Table-driven single-cycle grants.
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].wb_we, vecs[i].wb_wr, vecs[i].wb_wd,
            vecs[i].aux_valid, vecs[i].aux_wr, vecs[i].aux_wd);
      #1;
      chk($sformatf("vec%0d_aux_ready", i), aux_ready, vecs[i].exp_ready);
      tick();
      chk($sformatf("vec%0d_rf_we", i), rf_we, vecs[i].exp_we);
      chk($sformatf("vec%0d_rf_wr", i), rf_wr, vecs[i].exp_wr);
      chk($sformatf("vec%0d_rf_wd", i), rf_wd, vecs[i].exp_wd);
      chk($sformatf("vec%0d_stall", i), stall_wb, 1'b0);
    end
    chk("vec_err", err, 1'b0);

    // Starvation with STARVE_LIMIT=4.
    do_reset();
    drive(1'b1, 3'd4, 16'h4444, 1'b1, 3'd6, 16'hCAFE);
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("starve_c%0d_aux_ready", c), aux_ready, 1'b0);
      chk($sformatf("starve_c%0d_stall", c), stall_wb, 1'b0);
      tick();
    end
    #1;
    chk("starve_c4_stall", stall_wb, 1'b1);
    chk("starve_c4_aux_ready", aux_ready, 1'b1);
    chk("starve_c4_rf_wr", rf_wr, 3'd4);
    tick();
    aux_valid = 1'b0;
    #1;
    chk("starve_c5_stall", stall_wb, 1'b0);
    chk("starve_c5_rf_we", rf_we, 1'b1);
    chk("starve_c5_rf_wr", rf_wr, 3'd6);
    chk("starve_c5_rf_wd", rf_wd, 16'hCAFE);
    chk("starve_c5_aux_ready", aux_ready, 1'b0);
    tick();
    drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    chk("starve_c6_rf_we", rf_we, 1'b1);
    chk("starve_c6_rf_wr", rf_wr, 3'd4);
    chk("starve_c6_rf_wd", rf_wd, 16'h4444);
    chk("starve_c6_err", err, 1'b0);

    // Reset asserted while FORCE is active.
    do_reset();
    drive(1'b1, 3'd4, 16'h4444, 1'b1, 3'd6, 16'hCAFE);
    repeat (4) tick();
    chk("rstmid_pre_stall", stall_wb, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid_stall", stall_wb, 1'b0);
    chk("rstmid_rf_we", rf_we, 1'b0);
    chk("rstmid_aux_ready", aux_ready, 1'b0);
    #3;
    rst_n = 1'b1;
    tick();
    #1;
    chk("rstmid_normal_aux_ready", aux_ready, 1'b0);
    chk("rstmid_post_stall", stall_wb, 1'b0);
    chk("rstmid_post_err", err, 1'b0);

    // Protocol violation: aux data changes while blocked.
    do_reset();
    drive(1'b1, 3'd1, 16'h0, 1'b1, 3'd3, 16'h0001);
    tick();
    tick();
    aux_wd = 16'h0002;
    #1;
    chk("proto_err_before", err, 1'b0);
    tick();
    drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    chk("proto_err_set", err, 1'b1);
    repeat (3) tick();
    chk("proto_err_sticky", err, 1'b1);
    do_reset();
    chk("proto_err_cleared", err, 1'b0);

    // STARVE_LIMIT=1 with a same-register collision: writes land in grant order.
    do_reset();
    drive(1'b1, 3'd2, 16'hAAAA, 1'b1, 3'd2, 16'hBBBB);
    #1;
    chk("lim1_c0_aux_ready", aux_ready1, 1'b0);
    tick();
    wb_wd = 16'hCCCC;
    #1;
    chk("lim1_c1_stall", stall_wb1, 1'b1);
    chk("lim1_c1_aux_ready", aux_ready1, 1'b1);
    chk("lim1_c1_rf_wd", rf_wd1, 16'hAAAA);
    tick();
    aux_valid = 1'b0;
    chk("lim1_c2_stall", stall_wb1, 1'b0);
    chk("lim1_c2_rf_wr", rf_wr1, 3'd2);
    chk("lim1_c2_rf_wd", rf_wd1, 16'hBBBB);
    tick();
    drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    chk("lim1_c3_rf_we", rf_we1, 1'b1);
    chk("lim1_c3_rf_wd", rf_wd1, 16'hCCCC);
    chk("lim1_err", err1, 1'b0);
    tick();
    chk("lim1_c4_rf_we", rf_we1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_wr_arbiter.md
# regfile_wr_arbiter

Arbitrates the single register-file write port between the pipeline writeback stage and an auxiliary multi-cycle requester (multiply/divide unit or debug loader). Writeback has priority. The auxiliary requester uses a valid/ready handshake. A starvation counter stalls writeback for one cycle when the auxiliary request has waited too long. The block sits between the writeback stage and the decode-stage register file, and registers the write-port signals.

## Interface
- STARVE_LIMIT, 4: consecutive blocked cycles of a pending aux request before writeback is stalled; legal range 1..15
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- wb_we  in  1  writeback write enable (WriteToReg from writeback stage)
- wb_wr  in  3  writeback destination register
- wb_wd  in  16  writeback data
- aux_valid  in  1  aux request pending
- aux_wr  in  3  aux destination register
- aux_wd  in  16  aux data
- aux_ready  out  1  aux request granted this cycle (combinational)
- stall_wb  out  1  registered; pipeline holds writeback stage while high
- rf_we  out  1  register-file write enable (registered)
- rf_wr  out  3  register-file write register (registered)
- rf_wd  out  16  register-file write data (registered)
- err  out  1  sticky aux protocol violation flag; cleared only by reset

## Operation
- States: NORMAL, FORCE. Wait counter wait_cnt is 4 bits and saturates at 15.
- NORMAL grant:
  - wb_we=1: grant WB (rf_* <= wb_*, rf_we <= 1).
  - wb_we=0, aux_valid=1: grant aux (aux_ready=1, rf_* <= aux_*).
  - Neither: rf_we <= 0, and rf_wr/rf_wd hold.
- Blocked aux: aux_valid=1 and wb_we=1 in NORMAL. On each blocked cycle, wait_cnt increments.
  - If a blocked cycle occurs with wait_cnt == STARVE_LIMIT-1, the next state is FORCE, stall_wb <= 1, and wait_cnt <= 0.
- wait_cnt clears to 0 on any aux grant or any cycle with aux_valid=0.
- FORCE (stall_wb=1):
  - wb_we, wb_wr and wb_wd are ignored. The pipeline holds that write and re-presents it the following cycle.
  - aux is granted (aux_ready=1).
  - The next state is NORMAL and stall_wb <= 0.
- FORCE with aux_valid=0 is a protocol violation: err <= 1, rf_we <= 0, next state NORMAL, stall_wb <= 0.
- Aux protocol: once asserted, aux_valid and aux_wr/aux_wd must stay stable until aux_ready=1.
  - Dropping aux_valid, or changing aux_wr/aux_wd, while pending and not ready sets err. Arbitration continues normally.
  - Tracking uses a registered copy of aux_wr/aux_wd plus a pending flag set on a blocked cycle.
- Ordering: writes reach the register file in grant order. A same-register collision (wb_wr == aux_wr) needs no special handling; the later grant wins.
- aux_ready is never 1 in the same cycle as a WB grant.

## Timing
- Reset (rst_n low, asynchronous): state=NORMAL, wait_cnt=0, pending=0, stall_wb=0, rf_we=0, rf_wr=0, rf_wd=0, err=0.
- aux_ready is forced to 0 while rst_n is low.
- Latency: a grant in cycle N gives rf_we/rf_wr/rf_wd valid in cycle N+1. The register file writes at the end of cycle N+1.
- stall_wb is registered. The decision is made in cycle N, stall_wb is high in N+1, and is low again in N+2. Each FORCE episode therefore stalls writeback for exactly one cycle.
- With STARVE_LIMIT=1, a single blocked cycle triggers FORCE.
- Worst-case aux wait: STARVE_LIMIT blocked cycles, then 1 FORCE cycle.
- Reset asserted mid-FORCE: stall_wb drops immediately, and the pending aux request is lost. The requester must re-present it after reset.

## Test plan
- Reset mid-operation: assert rst_n=0 during FORCE -> stall_wb, rf_we and aux_ready go 0 asynchronously; after release, state is NORMAL and err=0.
- Single WB write: wb_we=1, wb_wr=3, wb_wd=16'hBEEF, aux idle -> next cycle rf_we=1, rf_wr=3, rf_wd=16'hBEEF; following idle cycle rf_we=0.
- Aux fills idle slot: wb_we=0, aux_valid=1, aux_wr=5, aux_wd=16'h1234 -> aux_ready=1 same cycle; next cycle rf_wr=5, rf_wd=16'h1234.
- Starvation (STARVE_LIMIT=4): wb_we=1 continuously and aux_valid=1 from cycle 0 -> aux_ready=0 for cycles 0-3, stall_wb=1 in cycle 4 with aux_ready=1, rf_wr=aux_wr in cycle 5, stall_wb=0 in cycle 5; the held WB write lands in cycle 6.
- Protocol violation: aux_valid=1 blocked for 2 cycles, then aux_wd changes from 16'h0001 to 16'h0002 before grant -> err=1 the next cycle and stays 1 until reset.
- STARVE_LIMIT=1 with wb_we=1 and aux_valid=1 -> stall_wb=1 on the cycle after the first blocked cycle; same-register collision (wb_wr=aux_wr=2) -> rf_wd sequence follows grant order.
